// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, response and memory-side signals of mem_access_ctrl.
interface mem_access_ctrl_if;
    logic       i_req;
    logic       i_we;
    logic       i_sel;
    logic [7:0] i_addr;
    logic [3:0] i_len;
    logic [7:0] i_wdata;
    logic       o_busy;
    logic       o_wtaken;
    logic [7:0] o_rdata;
    logic       o_rvalid;
    logic       o_done;
    logic       o_err;
    logic [7:0] o_address;
    logic       o_addressEn;
    logic [7:0] o_writeData;
    logic       o_writeEn;
    logic       o_readDataSelect;
    logic       o_outEnable;
    logic [7:0] i_readData;

    modport slave (
        input  i_req, i_we, i_sel, i_addr, i_len, i_wdata, i_readData,
        output o_busy, o_wtaken, o_rdata, o_rvalid, o_done, o_err,
               o_address, o_addressEn, o_writeData, o_writeEn, o_readDataSelect, o_outEnable
    );

    modport master (
        output i_req, i_we, i_sel, i_addr, i_len, i_wdata, i_readData,
        input  o_busy, o_wtaken, o_rdata, o_rvalid, o_done, o_err,
               o_address, o_addressEn, o_writeData, o_writeEn, o_readDataSelect, o_outEnable
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-beat read/write sequencer for a ROM/RAM memory port, all outputs registered.
module mem_access_ctrl #(
    parameter int READ_WAIT = 1
) (
    input logic              i_clk,
    input logic              i_nRst,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, DONE} state_t;

    state_t     state_q, state_d;
    logic       we_q, we_d, sel_q, sel_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0] len_q, len_d, wait_q, wait_d;
    logic       busy_q, busy_d, wtaken_q, wtaken_d, rvalid_q, rvalid_d;
    logic       done_q, done_d, err_q, err_d, ae_q, ae_d;
    logic       wen_q, wen_d, rds_q, rds_d, oe_q, oe_d;
    logic       beat_end, bad_req;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wait_d   = wait_q;
        bad_req  = bus.i_we && !bus.i_sel;
        beat_end = (state_q == WRITE) || (state_q == READ && wait_q == 4'(READ_WAIT - 1));
        case (state_q)
            IDLE: if (bus.i_req && !bad_req) begin
                we_d    = bus.i_we;
                sel_d   = bus.i_sel;
                addr_d  = bus.i_addr;
                len_d   = bus.i_len;
                state_d = ADDR;
            end
            ADDR: begin
                wait_d  = 4'd0;
                state_d = we_q ? WRITE : READ;
            end
            READ:    wait_d = wait_q + 4'd1;
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (beat_end) begin
            state_d = (len_q != 4'd0) ? ADDR : DONE;
            len_d   = (len_q != 4'd0) ? len_q - 4'd1 : len_q;
            addr_d  = (len_q != 4'd0) ? addr_q + 8'd1 : addr_q;
        end
        err_d    = state_q == IDLE && bus.i_req && bad_req;
        busy_d   = state_d != IDLE;
        ae_d     = state_d == ADDR;
        wen_d    = state_d == WRITE;
        wtaken_d = state_d == WRITE;
        oe_d     = state_d == READ;
        rds_d    = (state_d == WRITE) ? 1'b1 : (state_d == READ) ? sel_d : 1'b0;
        done_d   = state_d == DONE;
        wdata_d  = (state_d == WRITE) ? bus.i_wdata : wdata_q;
        rvalid_d = state_q == READ && beat_end;
        rdata_d  = rvalid_d ? bus.i_readData : rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= 8'd0;
            len_q    <= 4'd0;
            wait_q   <= 4'd0;
            wdata_q  <= 8'd0;
            rdata_q  <= 8'd0;
            busy_q   <= 1'b0;
            wtaken_q <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ae_q     <= 1'b0;
            wen_q    <= 1'b0;
            rds_q    <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wait_q   <= wait_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            wtaken_q <= wtaken_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ae_q     <= ae_d;
            wen_q    <= wen_d;
            rds_q    <= rds_d;
            oe_q     <= oe_d;
        end
    end

    assign bus.o_busy           = busy_q;
    assign bus.o_wtaken         = wtaken_q;
    assign bus.o_rdata          = rdata_q;
    assign bus.o_rvalid         = rvalid_q;
    assign bus.o_done           = done_q;
    assign bus.o_err            = err_q;
    assign bus.o_address        = addr_q;
    assign bus.o_addressEn      = ae_q;
    assign bus.o_writeData      = wdata_q;
    assign bus.o_writeEn        = wen_q;
    assign bus.o_readDataSelect = rds_q;
    assign bus.o_outEnable      = oe_q;
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter READ_WAIT, default 1: ACCESS-state cycles per read beat, legal range 1..15.
REQ-002 i_clk  in  1  system clock; all state changes on rising edge.
REQ-003 i_nRst  in  1  asynchronous, active-low reset.
REQ-004 i_req  in  1  start transfer; sampled only in IDLE.
REQ-005 i_we  in  1  1 = write, 0 = read; sampled with i_req.
REQ-006 i_sel  in  1  space select: 1 = data RAM, 0 = program ROM; sampled with i_req.
REQ-007 i_addr  in  8  start address; sampled with i_req.
REQ-008 i_len  in  4  beats minus one, so 0 means 1 beat and 15 means 16 beats; sampled with i_req.
REQ-009 i_wdata  in  8  write data for the current beat.
REQ-010 o_busy  out  1  high in every state except IDLE.
REQ-011 o_wtaken  out  1  one-cycle pulse when the current i_wdata beat is consumed.
REQ-012 o_rdata  out  8  registered read data.
REQ-013 o_rvalid  out  1  one-cycle pulse when o_rdata holds a new beat.
REQ-014 o_done  out  1  one-cycle pulse when the transfer completes.
REQ-015 o_err  out  1  one-cycle pulse when a request is rejected.
REQ-016 o_address  out  8  memory address bus.
REQ-017 o_addressEn  out  1  memory address-register load enable.
REQ-018 o_writeData  out  8  memory write data.
REQ-019 o_writeEn  out  1  memory write enable.
REQ-020 o_readDataSelect  out  1  memory space select.
REQ-021 o_outEnable  out  1  memory output enable.
REQ-022 i_readData  in  8  memory read bus.

Function
REQ-023 States SHALL be IDLE, ADDR, WRITE, READ and DONE; every output SHALL be driven from a register.
REQ-024 IDLE with i_req=1, i_we=1, i_sel=0 SHALL pulse o_err the next cycle, cause no memory-side activity, and stay IDLE.
REQ-025 IDLE with any other i_req=1 SHALL latch we, sel, addr and len, and go to ADDR the next cycle.
REQ-026 ADDR SHALL last 1 cycle and drive o_address=current address and o_addressEn=1; write: o_writeData<=i_wdata; then go to WRITE if we=1, otherwise to READ.
REQ-027 WRITE SHALL last 1 cycle and drive o_writeEn=1, o_readDataSelect=1 and o_outEnable=0, with o_writeData held stable, and pulse o_wtaken in the same cycle.
REQ-028 READ SHALL last READ_WAIT cycles and drive o_outEnable=1 and o_readDataSelect=sel; i_readData SHALL be captured into o_rdata on the edge that ends READ, and o_rvalid SHALL pulse the following cycle.
REQ-029 At the end of WRITE or READ: if the beat counter is nonzero, decrement it, increment the address modulo 256 (8'hFF wraps to 8'h00), and go to ADDR; otherwise go to DONE.
REQ-030 DONE SHALL last 1 cycle, pulse o_done, and return to IDLE; a new request SHALL be accepted no earlier than the cycle after DONE.
REQ-031 i_req while o_busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-032 o_writeEn and o_outEnable SHALL never be high in the same cycle; o_addressEn SHALL never coincide with o_writeEn.
REQ-033 Outside the states that assert them, o_addressEn, o_writeEn and o_outEnable SHALL be 0.
REQ-034 A 1-beat write SHALL take 4 cycles from request accept to o_done (ADDR, WRITE, DONE plus the accept edge); a 1-beat read SHALL take 3+READ_WAIT cycles.

Reset
REQ-035 i_nRst=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, all outputs=0 and internal counters=0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no o_done, and o_writeEn SHALL fall without waiting for a clock edge.
REQ-037 After reset release, the first rising edge with i_req=1 SHALL be accepted normally.

Verification
REQ-038 Write 1 beat, addr=8'h10, data=8'hA5, sel=1 -> o_addressEn one cycle with o_address=8'h10, then o_writeEn one cycle with o_writeData=8'hA5 and o_wtaken, then o_done.
REQ-039 Read 3 beats (len=2), addr=8'hFE, READ_WAIT=2, memory model returning the address as data -> o_rdata 8'hFE, 8'hFF, 8'h00 with three o_rvalid pulses, then o_done.
REQ-040 i_we=1, i_sel=0 -> o_err pulse, no o_addressEn or o_writeEn, o_busy stays 0.
REQ-041 i_req held high during a 4-beat write -> exactly one transfer, exactly 4 o_wtaken pulses, then a second transfer starting after DONE.
REQ-042 i_nRst dropped during WRITE -> o_writeEn=0 and o_busy=0 immediately, no o_done.
REQ-043 An assertion over all runs -> never (o_writeEn & o_outEnable) and never (o_writeEn & o_addressEn).
